// File: rtl/sap_programmer.sv
// sap_programmer
//
// Program loader placed upstream of the SAP-1 control block and the RAM/bus
// path. It gathers a DEPTH-byte program from the ui_in pins under an
// asynchronous byte strobe while holding the CPU in reset. It then releases
// the CPU with programming still high and hands one buffered byte to the bus
// each time the control block asks for it, advancing on every done_load. After
// the last write it drops programming so the CPU starts fetching from
// address 0, which the 4-bit PC has wrapped back to.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   ui_in        in   program byte from the pins (stable from strobe rise to byte_ack)
//   byte_strobe  in   asynchronous strobe, rising edge = new byte on ui_in
//   reprogram    in   single-cycle reload request, acted on only in RUN
//   read_ui_in   in   control block T3 of a programming cycle
//   done_load    in   control block T4 of a programming cycle (RAM write)
//   programming  out  to the control block programming input
//   cpu_reset    out  active-high CPU hold (inverted onto resetn at top level)
//   bus_out      out  buffered byte toward the bus
//   bus_oe       out  bus drive enable
//   byte_ack     out  one-cycle pulse per captured byte
//   prog_done    out  high while in RUN
//   byte_count   out  bytes captured (COLLECT) / written (REPLAY), DEPTH in RUN
module sap_programmer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ui_in,
  input  logic              byte_strobe,
  input  logic              reprogram,
  input  logic              read_ui_in,
  input  logic              done_load,
  output logic              programming,
  output logic              cpu_reset,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              byte_ack,
  output logic              prog_done,
  output logic [IDX_W:0]    byte_count
);

  localparam logic [IDX_W:0] LAST_IDX  = (IDX_W+1)'(DEPTH - 1);
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_REPLAY  = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W:0]    idx;
  logic [DATA_W-1:0] prog_buf [DEPTH];

  logic strobe_p0;
  logic strobe_p1;
  logic strobe_p2;
  logic strobe_edge;
  logic cap_en;

  // Stage p0/p1: two-flop synchronizer for the asynchronous strobe.
  // Stage p2: delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_p0 <= 1'b0;
      strobe_p1 <= 1'b0;
      strobe_p2 <= 1'b0;
    end else begin
      strobe_p0 <= byte_strobe;
      strobe_p1 <= strobe_p0;
      strobe_p2 <= strobe_p1;
    end
  end

  // One cycle per strobe rise; a strobe held high yields a single edge.
  assign strobe_edge = strobe_p1 & ~strobe_p2;

  // A reset in the same cycle as an edge suppresses the capture.
  assign cap_en = ~reset & strobe_edge & (state == S_COLLECT);

  // Program buffer: data only, no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      prog_buf[idx[IDX_W-1:0]] <= ui_in;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_COLLECT;
      idx         <= '0;
      cpu_reset   <= 1'b1;
      programming <= 1'b1;
      byte_ack    <= 1'b0;
      prog_done   <= 1'b0;
    end else begin
      byte_ack <= 1'b0;
      case (state)
        S_COLLECT: begin
          // cpu_reset is still held here on the final capture, so it falls
          // one cycle after the last byte_ack, from the REPLAY branch.
          cpu_reset   <= 1'b1;
          programming <= 1'b1;
          prog_done   <= 1'b0;
          if (strobe_edge) begin
            byte_ack <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= S_REPLAY;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_REPLAY: begin
          cpu_reset   <= 1'b0;
          programming <= 1'b1;
          prog_done   <= 1'b0;
          if (done_load) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state       <= S_RUN;
              programming <= 1'b0;
              prog_done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cpu_reset   <= 1'b0;
          programming <= 1'b0;
          prog_done   <= 1'b1;
          if (reprogram) begin
            state       <= S_COLLECT;
            idx         <= '0;
            cpu_reset   <= 1'b1;
            programming <= 1'b1;
            prog_done   <= 1'b0;
          end
        end
        default: begin
          state       <= S_COLLECT;
          idx         <= '0;
          cpu_reset   <= 1'b1;
          programming <= 1'b1;
          prog_done   <= 1'b0;
        end
      endcase
    end
  end

  // Bus path: idx only moves on the T4 edge, so bus_out is steady across T3.
  assign bus_out = prog_buf[idx[IDX_W-1:0]];
  assign bus_oe  = (state == S_REPLAY) & read_ui_in;

  always_comb begin
    byte_count = idx;
    if (state == S_RUN) begin
      byte_count = DEPTH_CNT;
    end
  end

endmodule

// File: tb/tb_sap_programmer.sv
module tb_sap_programmer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui_in;
  logic       byte_strobe;
  logic       reprogram;
  logic       read_ui_in;
  logic       done_load;
  logic       programming;
  logic       cpu_reset;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       byte_ack;
  logic       prog_done;
  logic [4:0] byte_count;

  int n_cmp   = 0;
  int n_err   = 0;
  int ack_cnt = 0;

  // Reference data: the program image being loaded and the RAM the
  // control-block model writes into, indexed by its own PC.
  logic [7:0] img    [DEPTH];
  logic [7:0] ram    [DEPTH];
  logic       ram_wr [DEPTH];
  int         pc;

  always #5 clk = ~clk;

  sap_programmer #(.DEPTH(16), .IDX_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ui_in       (ui_in),
    .byte_strobe (byte_strobe),
    .reprogram   (reprogram),
    .read_ui_in  (read_ui_in),
    .done_load   (done_load),
    .programming (programming),
    .cpu_reset   (cpu_reset),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .byte_ack    (byte_ack),
    .prog_done   (prog_done),
    .byte_count  (byte_count)
  );

  // Count every byte_ack cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_ack === 1'b1) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One strobe: high for hi cycles (>=4), low for lo cycles.
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo,
                           input bit last, input int cnt_after);
    int a0;
    @(negedge clk);
    ui_in       = b;
    byte_strobe = 1'b1;
    a0          = ack_cnt;
    repeat (2) @(posedge clk);
    #1 chk("ack_before_edge3", 32'(byte_ack), 0);
    @(posedge clk);
    #1 chk("ack_at_edge3", 32'(byte_ack), 1);
    chk("count_at_ack", 32'(byte_count), last ? 0 : cnt_after);
    chk("cpu_reset_at_ack", 32'(cpu_reset), 1);
    @(posedge clk);
    #1 chk("ack_one_cycle", 32'(byte_ack), 0);
    chk("cpu_reset_after_ack", 32'(cpu_reset), last ? 0 : 1);
    repeat (hi - 4) @(posedge clk);
    @(negedge clk);
    byte_strobe = 1'b0;
    repeat (lo) @(posedge clk);
    #1 chk("acks_per_strobe", ack_cnt - a0, 1);
  endtask

  task automatic collect(input bit hold_first);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(img[i], (i == 0 && hold_first) ? 20 : int'($urandom_range(4, 6)),
                int'($urandom_range(2, 5)), i == DEPTH - 1, i + 1);
    end
  endtask

  // Control-block model: 7-cycle loop T0..T6, outputs change on falling
  // edges, T3 reads the bus, T4 writes RAM[pc] and advances pc.
  task automatic replay(input int stop_after);
    int         a0;
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 8'h00;
      ram_wr[i] = 1'b0;
    end
    pc = 0;
    a0 = ack_cnt;
    for (int k = 0; k < stop_after; k++) begin
      @(negedge clk);  // T0
      if (k == 3) begin
        ui_in       = 8'hEE;
        byte_strobe = 1'b1;
      end
      if (k == 6) byte_strobe = 1'b0;
      @(negedge clk);  // T1
      @(negedge clk);  // T2
      #1 chk("bus_oe_idle", 32'(bus_oe), 0);
      @(negedge clk);  // T3
      read_ui_in = 1'b1;
      #1 chk("bus_oe_read", 32'(bus_oe), 1);
      chk("bus_out", 32'(bus_out), 32'(img[k]));
      chk("count_replay", 32'(byte_count), k);
      chk("prog_in_replay", 32'(programming), 1);
      chk("cpu_released", 32'(cpu_reset), 0);
      v = bus_out;
      @(negedge clk);  // T4
      read_ui_in = 1'b0;
      done_load  = 1'b1;
      ram[pc]    = v;
      ram_wr[pc] = 1'b1;
      pc         = (pc + 1) % DEPTH;
      @(posedge clk);
      #1;
      if (k == DEPTH - 1) begin
        chk("prog_fall", 32'(programming), 0);
        chk("prog_done_set", 32'(prog_done), 1);
        chk("count_run", 32'(byte_count), DEPTH);
      end else begin
        chk("prog_hold", 32'(programming), 1);
        chk("count_step", 32'(byte_count), k + 1);
      end
      @(negedge clk);  // T5
      done_load = 1'b0;
      @(negedge clk);  // T6
    end
    @(negedge clk);
    byte_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("no_ack_in_replay", ack_cnt - a0, 0);
    if (stop_after == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        chk("ram_written", 32'(ram_wr[i]), 1);
        chk("ram_data", 32'(ram[i]), 32'(img[i]));
      end
      chk("next_fetch_addr", pc, 0);
    end
  endtask

  task automatic check_run();
    @(posedge clk);
    #1 chk("run_prog_done", 32'(prog_done), 1);
    chk("run_programming", 32'(programming), 0);
    chk("run_cpu_reset", 32'(cpu_reset), 0);
    chk("run_count", 32'(byte_count), DEPTH);
    @(negedge clk);
    read_ui_in = 1'b1;
    done_load  = 1'b1;
    #1 chk("run_bus_oe", 32'(bus_oe), 0);
    @(posedge clk);
    #1 chk("run_done_load_ignored", 32'(byte_count), DEPTH);
    @(negedge clk);
    read_ui_in = 1'b0;
    done_load  = 1'b0;
  endtask

  task automatic do_reprogram();
    @(negedge clk);
    reprogram = 1'b1;
    @(posedge clk);
    #1 chk("reprog_cpu_reset", 32'(cpu_reset), 1);
    chk("reprog_programming", 32'(programming), 1);
    chk("reprog_prog_done", 32'(prog_done), 0);
    chk("reprog_count", 32'(byte_count), 0);
    @(negedge clk);
    reprogram = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ui_in       = 8'h00;
    byte_strobe = 1'b0;
    reprogram   = 1'b0;
    read_ui_in  = 1'b1;
    done_load   = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_programming", 32'(programming), 1);
    chk("rst_prog_done", 32'(prog_done), 0);
    chk("rst_count", 32'(byte_count), 0);
    chk("rst_bus_oe", 32'(bus_oe), 0);
    chk("rst_byte_ack", 32'(byte_ack), 0);
    @(negedge clk);
    reset      = 1'b0;
    read_ui_in = 1'b0;

    // reprogram outside RUN has no effect
    @(negedge clk);
    reprogram = 1'b1;
    @(negedge clk);
    reprogram = 1'b0;
    #1 chk("reprog_ignored_cpu", 32'(cpu_reset), 1);
    chk("reprog_ignored_cnt", 32'(byte_count), 0);

    for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'h10 + i);
    collect(1'b0);
    replay(DEPTH);
    check_run();

    do_reprogram();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'hA0 + i);
    collect(1'b1);
    replay(DEPTH);
    check_run();

    do_reprogram();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    collect(1'b0);
    replay(5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("midrst_cpu_reset", 32'(cpu_reset), 1);
    chk("midrst_programming", 32'(programming), 1);
    chk("midrst_count", 32'(byte_count), 0);
    chk("midrst_prog_done", 32'(prog_done), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    collect(1'b0);
    replay(DEPTH);
    check_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sap_programmer.md
# sap_programmer

Program loader that sits directly upstream of the SAP-1 control block and the RAM/bus path. It collects a 16-byte program from the `ui_in` pins under an asynchronous byte strobe and holds the CPU in reset while it does so. It then releases the CPU with `programming` high, drives each buffered byte onto the bus when the control block raises `read_ui_in`, and counts `done_load` pulses. After the last byte it drops `programming` so the CPU fetches from address 0.

## Interface
- `DEPTH`, 16: program length in bytes; equals RAM size, so the 4-bit PC wraps to 0 after the last write.
- `IDX_W`, 4: replay/collect index width, $clog2(DEPTH).
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ui_in` in 8: program byte from the pins; must be stable from the strobe rise until `byte_ack`.
- `byte_strobe` in 1: asynchronous strobe from the pins; a rising edge means a new byte is on `ui_in`.
- `reprogram` in 1: synchronous single-cycle request to reload the program; honoured only in RUN.
- `read_ui_in` in 1: from the control block; high during T3 of a programming cycle.
- `done_load` in 1: from the control block; high during T4 of a programming cycle, when the RAM write occurs.
- `programming` out 1: to the control block's `programming` input.
- `cpu_reset` out 1: active-high hold to the CPU; the top level inverts it onto `resetn`.
- `bus_out` out 8: buffered byte driven toward the bus.
- `bus_oe` out 1: bus drive enable.
- `byte_ack` out 1: one-cycle pulse when a byte is captured.
- `prog_done` out 1: high while in RUN.
- `byte_count` out IDX_W+1: bytes captured in COLLECT, or bytes written in REPLAY.

## Operation
- Storage: DEPTH×8 register buffer. Index `idx` is IDX_W+1 bits so it can hold DEPTH.
- Strobe path: 2-flop synchronizer, then a third flop for rising-edge detect. `edge` is one cycle per strobe rise; a strobe held high gives one edge only.
- COLLECT (reset state):
  - Outputs: `cpu_reset`=1, `programming`=1, `bus_oe`=0.
  - On `edge`: `buf[idx]<=ui_in`, `idx<=idx+1`, `byte_ack`=1 on the same cycle.
  - When `edge` arrives with idx==DEPTH-1, go to REPLAY and clear idx.
- REPLAY:
  - Outputs: `cpu_reset`=0, `programming`=1.
  - `bus_oe = read_ui_in` (combinational). `bus_out = buf[idx[IDX_W-1:0]]`.
  - On a sampled `done_load`: `idx<=idx+1`.
  - When `done_load` is sampled with idx==DEPTH-1, go to RUN.
  - `edge` is ignored; no `byte_ack`.
- RUN:
  - Outputs: `programming`=0, `cpu_reset`=0, `bus_oe`=0, `prog_done`=1.
  - `reprogram`=1 goes to COLLECT with idx=0. Buffer contents are retained and overwritten as new bytes arrive.
- `byte_count` = idx in COLLECT and REPLAY, DEPTH in RUN.
- Reset outputs: state=COLLECT, idx=0, `cpu_reset`=1, `programming`=1, `bus_oe`=0, `bus_out`=buf[0] (contents undefined), `byte_ack`=0, `prog_done`=0, `byte_count`=0, synchronizer flops=0.
- Reset during REPLAY or RUN returns to COLLECT and reasserts `cpu_reset` on the next cycle. The partial RAM image is discarded logically; the full DEPTH bytes must be collected again.
- Reset and `edge` in the same cycle: reset wins and the byte is not captured.
- `reprogram` outside RUN: ignored.
- `done_load` outside REPLAY: ignored.

## Timing
- Strobe to capture: `byte_ack` is asserted on the 3rd rising edge after `byte_strobe` rises, when setup is met.
- Minimum strobe high and low time: 2 `clk` cycles each.
- Control block outputs change on the falling edge. Each `done_load` pulse is therefore seen at exactly one rising edge, and increments idx once.
- `bus_out` is stable for the whole `read_ui_in` window: idx changes only at the T4 rising edge.
- COLLECT→REPLAY: `cpu_reset` falls on the cycle after the last `byte_ack`. The control block holds one cycle in stage 6, then enters T0 with PC=0.
- REPLAY→RUN: `programming` falls on the cycle after the last `done_load` is sampled, which is before the next T2. The first instruction fetch is therefore from address 0 after the PC wraps.
- Throughput: one byte written per 7-cycle control-block loop; full replay takes DEPTH×7 cycles.

## Test plan
- Reset and idle: assert `reset` 2 cycles -> `cpu_reset`=1, `programming`=1, `prog_done`=0, `byte_count`=0, `bus_oe`=0.
- Collect: 16 strobes with `ui_in`=0x10..0x1F, strobes 4 cycles high/4 low -> 16 `byte_ack` pulses, each 3 cycles after its strobe rise; `cpu_reset` falls 1 cycle after the 16th ack.
- Replay: with the control-block model -> on the k-th `read_ui_in`, `bus_oe`=1 and `bus_out`=0x10+k; RAM model holds 0x10..0x1F at addresses 0..15; `programming` falls after the 16th `done_load`, and the next fetch address is 0.
- Glitch rejection: `byte_strobe` held high 20 cycles -> exactly one capture; a strobe during REPLAY -> no ack and buffer unchanged.
- Reprogram: `reprogram` pulse in RUN -> COLLECT, `cpu_reset`=1, `byte_count`=0; a new image 0xA0..0xAF is replayed correctly.
- Reset mid-replay: `reset` after the 5th `done_load` -> COLLECT; the next full collect and replay writes all 16 bytes starting at address 0.
